// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM; shadow positions load atomically into the active set at each frame boundary.
// pwm_out is registered one clk behind frame_cnt; writes are accepted every cycle with no backpressure.
module servo_pwm_bank #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 50,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_TICKS    = 1000,
  parameter int STEP_TICKS   = 4,
  parameter int MAX_TICKS    = 2000,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_pos,
  input  logic                wr_enable,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start,
  output logic                update_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(PERIOD_TICKS - 1);

  logic [PW-1:0]       prescale_cnt;
  logic [FW-1:0]       frame_cnt;
  logic                tick;
  logic                load_evt;
  logic                wr_accept;

  logic [WIDTH-1:0]    shadow_pos   [CHANNELS];
  logic [CHANNELS-1:0] shadow_en;
  logic [FW-1:0]       pulse_active [CHANNELS];
  logic [CHANNELS-1:0] en_active;

  // Clamped pulse width fits in FW bits because MAX_TICKS < PERIOD_TICKS.
  function automatic logic [FW-1:0] pulse_width(input logic [WIDTH-1:0] pos);
    logic [31:0] raw;
    raw = 32'(MIN_TICKS) + 32'(pos) * 32'(STEP_TICKS);
    if (raw > 32'(MAX_TICKS)) begin
      raw = 32'(MAX_TICKS);
    end
    return raw[FW-1:0];
  endfunction

  assign tick      = (prescale_cnt == PS_LAST);
  assign load_evt  = tick && (frame_cnt == FR_LAST);
  assign wr_accept = wr_en && (32'(wr_chan) < 32'(CHANNELS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      if (tick) begin
        prescale_cnt <= '0;
        if (frame_cnt == FR_LAST) begin
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        prescale_cnt <= prescale_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_pos[i] <= '0;
      end
      shadow_en <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_accept && (wr_chan == CW'(i))) begin
          shadow_pos[i] <= wr_pos;
          shadow_en[i]  <= wr_enable;
        end
      end
    end
  end

  // Same-cycle write and load: the load samples the shadow before the write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pulse_active[i] <= '0;
      end
      en_active   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load_evt;
      if (load_evt) begin
        for (int i = 0; i < CHANNELS; i++) begin
          pulse_active[i] <= pulse_width(shadow_pos[i]);
        end
        en_active <= shadow_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= en_active[i] && (frame_cnt < pulse_active[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_pending <= 1'b0;
    end else if (wr_accept) begin
      update_pending <= 1'b1;
    end else if (load_evt) begin
      update_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: directed frame scenarios plus random writes, checked every cycle
// against a model that works in absolute clk counts since reset release.
module tb_servo_pwm_bank;

  localparam int CH        = 3;
  localparam int WIDTH     = 8;
  localparam int PRESCALE  = 2;
  localparam int PERIOD    = 100;
  localparam int MINT      = 10;
  localparam int STEPT     = 1;
  localparam int MAXT      = 20;
  localparam int CW        = (CH > 1) ? $clog2(CH) : 1;
  localparam int FRAME_CLK = PRESCALE * PERIOD;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [CW-1:0]    wr_chan;
  logic [WIDTH-1:0] wr_pos;
  logic             wr_enable;
  logic [CH-1:0]    pwm_out;
  logic             frame_start;
  logic             update_pending;

  servo_pwm_bank #(
    .CHANNELS(CH), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .PERIOD_TICKS(PERIOD),
    .MIN_TICKS(MINT), .STEP_TICKS(STEPT), .MAX_TICKS(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan), .wr_pos(wr_pos),
    .wr_enable(wr_enable), .pwm_out(pwm_out), .frame_start(frame_start),
    .update_pending(update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model state: n = clk edges since reset release; frame_base = edge of the last load.
  int n;
  int frame_base;
  int sh_pos [CH];
  bit sh_en  [CH];
  int act_pos[CH];
  bit act_en [CH];
  bit pend;
  int hi_cnt [CH];
  int fs_cnt;

  function automatic int exp_pulse(input int pos);
    int r;
    r = MINT + pos * STEPT;
    if (r > MAXT) r = MAXT;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic reset_model();
    n = 0;
    frame_base = 0;
    pend = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < CH; i++) begin
      sh_pos[i] = 0; sh_en[i] = 1'b0; act_pos[i] = 0; act_en[i] = 1'b0; hi_cnt[i] = 0;
    end
  endtask

  task automatic step(input bit we, input int ch, input int pos, input bit en);
    bit load;
    bit acc;
    logic [CH-1:0] ep;
    wr_en     = we;
    wr_chan   = CW'(ch);
    wr_pos    = WIDTH'(pos);
    wr_enable = en;
    @(posedge clk);
    n++;
    load = (n % FRAME_CLK == 0);
    if (load) begin
      for (int i = 0; i < CH; i++) begin
        act_pos[i] = sh_pos[i];
        act_en[i]  = sh_en[i];
      end
      frame_base = n;
    end
    acc = we && (ch < CH);
    if (acc) begin
      sh_pos[ch] = pos;
      sh_en[ch]  = en;
      pend = 1'b1;
    end else if (load) begin
      pend = 1'b0;
    end
    for (int i = 0; i < CH; i++) begin
      ep[i] = act_en[i] && (n - frame_base >= 1) &&
              (n - frame_base <= PRESCALE * exp_pulse(act_pos[i]));
    end
    #1;
    check("pwm_out", 32'(pwm_out), 32'(ep));
    check("frame_start", 32'(frame_start), 32'(load));
    check("update_pending", 32'(update_pending), 32'(pend));
    for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
    fs_cnt += int'(frame_start);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input int wr_off, input int ch, input int pos, input bit en);
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    for (int k = 1; k <= FRAME_CLK; k++) step(k == wr_off, ch, pos, en);
  endtask

  task automatic advance_to_load();
    step(1'b0, 0, 0, 1'b0);
    while (n % FRAME_CLK != 0) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_pos = '0; wr_enable = 1'b0;
    reset_model();
    #2;
    check("rst_pwm", 32'(pwm_out), 32'(0));
    check("rst_fs", 32'(frame_start), 32'(0));
    check("rst_pend", 32'(update_pending), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Three idle frames: first frame_start at edge 200, then every 200.
    repeat (3 * FRAME_CLK) step(1'b0, 0, 0, 1'b0);
    check("idle_fs_count", 32'(fs_cnt), 32'(3));

    repeat (5) step(1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 5, 1'b1);
    check("pend_after_write", 32'(update_pending), 32'(1));
    advance_to_load();
    check("pend_after_load", 32'(update_pending), 32'(0));
    run_frame(0, 0, 0, 1'b0);
    check("ch0_pos5_high", 32'(hi_cnt[0]), 32'(30));
    check("ch1_idle_high", 32'(hi_cnt[1]), 32'(0));

    // Clamp: 10+200 ticks limited to 20.
    step(1'b1, 1, 200, 1'b1);
    advance_to_load();
    run_frame(0, 0, 0, 1'b0);
    check("ch1_clamp_high", 32'(hi_cnt[1]), 32'(40));
    check("ch0_still_30", 32'(hi_cnt[0]), 32'(30));

    // Mid-frame write at frame_cnt=3 must not alter the running pulse.
    run_frame(7, 0, 9, 1'b1);
    check("midframe_cur", 32'(hi_cnt[0]), 32'(30));
    run_frame(0, 0, 0, 1'b0);
    check("midframe_next", 32'(hi_cnt[0]), 32'(38));

    // Write lands on the exact load edge.
    run_frame(FRAME_CLK, 0, 0, 1'b1);
    check("collide_pend", 32'(update_pending), 32'(1));
    run_frame(0, 0, 0, 1'b0);
    check("collide_old_val", 32'(hi_cnt[0]), 32'(38));
    run_frame(0, 0, 0, 1'b0);
    check("collide_new_val", 32'(hi_cnt[0]), 32'(20));
    check("collide_pend_clr", 32'(update_pending), 32'(0));

    step(1'b1, 3, 77, 1'b1);
    check("oob_write_pend", 32'(update_pending), 32'(0));

    for (int k = 0; k < 10 * FRAME_CLK; k++) begin
      step($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Async reset while ch0 is mid-pulse.
    step(1'b1, 0, 50, 1'b1);
    advance_to_load();
    repeat (5) step(1'b0, 0, 0, 1'b0);
    check("pre_reset_high", 32'(pwm_out[0]), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'(0));
    check("async_rst_fs", 32'(frame_start), 32'(0));
    check("async_rst_pend", 32'(update_pending), 32'(0));
    #2;
    rst = 1'b1;
    reset_model();
    repeat (2 * FRAME_CLK) step(1'b0, 0, 0, 1'b0);
    check("post_rst_high", 32'(hi_cnt[0]), 32'(0));
    check("post_rst_fs_count", 32'(fs_cnt), 32'(2));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
